// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared constants for the parametrised UART transmitter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    localparam logic c_PARITY_EVEN = 1'b0;
    localparam logic c_PARITY_ODD  = 1'b1;

    localparam logic c_STOP_1 = 1'b0;
    localparam logic c_STOP_2 = 1'b1;

    localparam int c_DATA_WIDTH_MIN = 5;
    localparam int c_DATA_WIDTH_MAX = 9;

endpackage

`default_nettype wire

// File: rtl/uart_tx_param_if.sv
// ============================================================================
// Module : uart_tx_param_if
// Brief  : Word/config handshake between the system side and the UART TX.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_tx_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 8
);
    logic                  data_valid;
    logic                  data_ready;
    logic [DATA_WIDTH-1:0] P_Data;
    logic                  parity_en;
    logic                  parity_type;
    logic                  stop_bits;
    logic [PRESCALE_W-1:0] prescale;

    modport master (
        output data_valid, P_Data, parity_en, parity_type, stop_bits, prescale,
        input  data_ready
    );

    modport slave (
        input  data_valid, P_Data, parity_en, parity_type, stop_bits, prescale,
        output data_ready
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_baud_cnt.sv
// ============================================================================
// Module : uart_tx_baud_cnt
// Brief  : Loadable per-bit prescale counter; strobes o_bit_done on the last
//          clock of each bit period.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_baud_cnt #(
    parameter int PRESCALE_W = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_load,
    input  wire logic [PRESCALE_W-1:0] i_prescale,
    input  wire logic                  i_en,
    output logic                       o_bit_done
);

    logic [PRESCALE_W-1:0] r_cnt;
    logic [PRESCALE_W-1:0] r_last;
    logic [PRESCALE_W-1:0] w_last;

    // A prescale of zero behaves exactly like one clock per bit.
    assign w_last     = (i_prescale == '0) ? '0 : i_prescale - PRESCALE_W'(1);
    assign o_bit_done = i_en && (r_cnt == r_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_last <= '0;
        end else if (i_load) begin
            r_cnt  <= '0;
            r_last <= w_last;
        end else if (i_en) begin
            r_cnt <= o_bit_done ? '0 : r_cnt + PRESCALE_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_param.sv
// ============================================================================
// Module : uart_tx_param
// Brief  : Parametrised UART transmitter with one-entry holding buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 8
) (
    input  wire logic       clk,
    input  wire logic       rst,
    uart_tx_param_if.slave  tx_if,
    output logic            TX_OUT,
    output logic            busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    if (DATA_WIDTH < c_DATA_WIDTH_MIN || DATA_WIDTH > c_DATA_WIDTH_MAX) begin : g_bad_width
        $error("uart_tx_param: DATA_WIDTH out of range");
    end

    logic                  r_buf_full;
    logic [DATA_WIDTH-1:0] r_buf_data;
    logic                  r_buf_par_en;
    logic                  r_buf_par_type;
    logic                  r_buf_stop_sel;
    logic [PRESCALE_W-1:0] r_buf_prescale;

    logic [2:0]            r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [IDX_W-1:0]      r_bit_idx;
    logic                  r_par_en;
    logic                  r_parity;
    logic                  r_stop_sel;
    logic                  r_stop_cnt;
    logic                  r_tx;
    logic                  r_busy;

    logic w_accept;
    logic w_bit_done;
    logic w_last_stop;
    logic w_load;

    assign tx_if.data_ready = !r_buf_full;
    assign TX_OUT           = r_tx;
    assign busy             = r_busy;

    assign w_accept    = tx_if.data_valid && !r_buf_full;
    assign w_last_stop = (r_state == c_ST_STOP) && w_bit_done &&
                         ((r_stop_sel == c_STOP_1) || r_stop_cnt);
    // Loading from STOP on the final stop edge gives zero-gap back-to-back frames.
    assign w_load      = r_buf_full && ((r_state == c_ST_IDLE) || w_last_stop);

    uart_tx_baud_cnt #(
        .PRESCALE_W (PRESCALE_W)
    ) u_baud_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_prescale (r_buf_prescale),
        .i_en       (r_state != c_ST_IDLE),
        .o_bit_done (w_bit_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf_full     <= 1'b0;
            r_buf_data     <= '0;
            r_buf_par_en   <= 1'b0;
            r_buf_par_type <= 1'b0;
            r_buf_stop_sel <= 1'b0;
            r_buf_prescale <= '0;
        end else if (w_load) begin
            r_buf_full <= 1'b0;
        end else if (w_accept) begin
            r_buf_full     <= 1'b1;
            r_buf_data     <= tx_if.P_Data;
            r_buf_par_en   <= tx_if.parity_en;
            r_buf_par_type <= tx_if.parity_type;
            r_buf_stop_sel <= tx_if.stop_bits;
            r_buf_prescale <= tx_if.prescale;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_ST_IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_par_en   <= 1'b0;
            r_parity   <= 1'b0;
            r_stop_sel <= 1'b0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else if (w_load) begin
            r_state    <= c_ST_START;
            r_shift    <= r_buf_data;
            r_par_en   <= r_buf_par_en;
            r_parity   <= (^r_buf_data) ^ (r_buf_par_type == c_PARITY_ODD);
            r_stop_sel <= r_buf_stop_sel;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
        end else if (w_bit_done) begin
            case (r_state)
                c_ST_START: begin
                    r_tx      <= r_shift[0];
                    r_shift   <= {1'b0, r_shift[DATA_WIDTH-1:1]};
                    r_bit_idx <= '0;
                    r_state   <= c_ST_DATA;
                end
                c_ST_DATA: begin
                    if (r_bit_idx == c_LAST_IDX) begin
                        if (r_par_en) begin
                            r_tx    <= r_parity;
                            r_state <= c_ST_PARITY;
                        end else begin
                            r_tx       <= 1'b1;
                            r_stop_cnt <= 1'b0;
                            r_state    <= c_ST_STOP;
                        end
                    end else begin
                        r_tx      <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[DATA_WIDTH-1:1]};
                        r_bit_idx <= r_bit_idx + IDX_W'(1);
                    end
                end
                c_ST_PARITY: begin
                    r_tx       <= 1'b1;
                    r_stop_cnt <= 1'b0;
                    r_state    <= c_ST_STOP;
                end
                c_ST_STOP: begin
                    if (w_last_stop) begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_stop_cnt <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_param.sv
// ============================================================================
// Module : tb_uart_tx_param
// Brief  : Self-checking bench for uart_tx_param (8-bit and 7-bit instances).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_param;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_param_if #(.DATA_WIDTH(8), .PRESCALE_W(8)) if8 ();
    uart_tx_param_if #(.DATA_WIDTH(7), .PRESCALE_W(8)) if7 ();

    logic tx8, busy8, tx7, busy7;

    uart_tx_param #(.DATA_WIDTH(8), .PRESCALE_W(8)) dut8 (
        .clk (clk), .rst (rst), .tx_if (if8), .TX_OUT (tx8), .busy (busy8)
    );
    uart_tx_param #(.DATA_WIDTH(7), .PRESCALE_W(8)) dut7 (
        .clk (clk), .rst (rst), .tx_if (if7), .TX_OUT (tx7), .busy (busy7)
    );

    int total = 0;
    int bad   = 0;
    bit exp_q[$];

    function automatic logic f_tx(bit s);    return s ? tx7 : tx8; endfunction
    function automatic logic f_busy(bit s);  return s ? busy7 : busy8; endfunction
    function automatic logic f_ready(bit s); return s ? if7.data_ready : if8.data_ready; endfunction

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: start, LSB-first data, optional parity, stop(s); each bit P clocks.
    task automatic build_frame(logic [8:0] data, int dw, bit pe, bit pt, bit sb, int ps);
        bit bits[$];
        bit par;
        int p;
        p   = (ps == 0) ? 1 : ps;
        par = pt;
        bits.push_back(1'b0);
        for (int i = 0; i < dw; i++) begin
            bits.push_back(data[i]);
            par = par ^ data[i];
        end
        if (pe) bits.push_back(par);
        bits.push_back(1'b1);
        if (sb) bits.push_back(1'b1);
        foreach (bits[j]) repeat (p) exp_q.push_back(bits[j]);
    endtask

    task automatic drive(bit s, logic [8:0] data, bit pe, bit pt, bit sb, int ps, bit v);
        if8.P_Data      = data[7:0];
        if7.P_Data      = data[6:0];
        if8.parity_en   = pe;  if7.parity_en   = pe;
        if8.parity_type = pt;  if7.parity_type = pt;
        if8.stop_bits   = sb;  if7.stop_bits   = sb;
        if8.prescale    = 8'(ps);
        if7.prescale    = 8'(ps);
        if8.data_valid  = v && !s;
        if7.data_valid  = v && s;
    endtask

    task automatic wait_ready(bit s);
        int n = 0;
        while (!f_ready(s) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("ready_timeout", 16'(f_ready(s)), 16'd1);
    endtask

    task automatic xfer(bit s, logic [8:0] data, bit pe, bit pt, bit sb, int ps,
                        bit has2, logic [8:0] data2);
        int dw;
        dw = s ? 7 : 8;
        exp_q.delete();
        build_frame(data, dw, pe, pt, sb, ps);
        if (has2) build_frame(data2, dw, pe, pt, sb, ps);
        @(negedge clk);
        wait_ready(s);
        drive(s, data, pe, pt, sb, ps, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(s, data, pe, pt, sb, ps, 1'b0);
        chk("ready_after_accept", 16'(f_ready(s)), 16'd0);
        chk("busy_before_load",   16'(f_busy(s)),  16'd0);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            chk("tx_bit",        16'(f_tx(s)),   16'(exp_q[i]));
            chk("busy_in_frame", 16'(f_busy(s)), 16'd1);
            if (has2 && i == 0) begin
                chk("ready_reopen", 16'(f_ready(s)), 16'd1);
                drive(s, data2, pe, pt, sb, ps, 1'b1);
            end
            if (has2 && i == 1) begin
                chk("ready_held", 16'(f_ready(s)), 16'd0);
                drive(s, data2, pe, pt, sb, ps, 1'b0);
            end
        end
        @(negedge clk);
        chk("busy_fall",  16'(f_busy(s)),  16'd0);
        chk("tx_idle",    16'(f_tx(s)),    16'd1);
        chk("ready_idle", 16'(f_ready(s)), 16'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        drive(1'b0, 9'd0, 1'b0, c_PARITY_EVEN, c_STOP_1, 1, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_tx8",    16'(tx8),            16'd1);
        chk("rst_busy8",  16'(busy8),          16'd0);
        chk("rst_ready8", 16'(if8.data_ready), 16'd1);
        chk("rst_tx7",    16'(tx7),            16'd1);
        chk("rst_ready7", 16'(if7.data_ready), 16'd1);
        rst = 1'b1;

        // Directed frames: even/odd parity, 7-bit two stops, prescale 4, prescale 0.
        xfer(1'b0, 9'h0A5, 1'b1, c_PARITY_EVEN, c_STOP_1, 1, 1'b0, 9'h0);
        xfer(1'b0, 9'h0A5, 1'b1, c_PARITY_ODD,  c_STOP_1, 1, 1'b0, 9'h0);
        xfer(1'b1, 9'h041, 1'b1, c_PARITY_ODD,  c_STOP_2, 1, 1'b0, 9'h0);
        xfer(1'b0, 9'h00F, 1'b0, c_PARITY_EVEN, c_STOP_1, 4, 1'b0, 9'h0);
        xfer(1'b0, 9'h03C, 1'b1, c_PARITY_ODD,  c_STOP_2, 0, 1'b0, 9'h0);

        // Back-to-back frames with no idle gap.
        xfer(1'b0, 9'h0C6, 1'b0, c_PARITY_EVEN, c_STOP_1, 1, 1'b1, 9'h052);
        xfer(1'b0, 9'h0C6, 1'b1, c_PARITY_ODD,  c_STOP_2, 3, 1'b1, 9'h052);

        // Asynchronous reset in the middle of the data bits.
        @(negedge clk);
        drive(1'b0, 9'h0FF, 1'b0, c_PARITY_EVEN, c_STOP_1, 4, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 9'h0FF, 1'b0, c_PARITY_EVEN, c_STOP_1, 4, 1'b0);
        repeat (12) @(negedge clk);
        chk("busy_mid_frame", 16'(busy8), 16'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_tx",    16'(tx8),            16'd1);
        chk("arst_busy",  16'(busy8),          16'd0);
        chk("arst_ready", 16'(if8.data_ready), 16'd1);
        @(negedge clk);
        rst = 1'b1;
        xfer(1'b0, 9'h000, 1'b0, c_PARITY_EVEN, c_STOP_1, 1, 1'b0, 9'h0);

        // Randomised frames against the reference model.
        for (int k = 0; k < 12; k++) begin
            xfer(1'($urandom_range(0, 1)), 9'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 9'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
